// File: rtl/pht_update_queue.sv
// Queue between branch resolution and the PHT write ports; computes saturating counter updates
// and pairs writes only across banks. Optional PHT_UPD_MERGE_EN merges same-index head pairs.
module pht_update_queue #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned IN_WIDTH   = 2,
   parameter int unsigned OUT_WIDTH  = 2,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 9,
   parameter int unsigned HIST_WIDTH = 2,
   parameter int unsigned CTR_WIDTH  = 2,
   parameter int unsigned ENT_WIDTH  = (2**HIST_WIDTH)*CTR_WIDTH
) (
   input  logic                            clk,
   input  logic                            rstN,
   input  logic [IN_WIDTH-1:0]             inValid,
   input  logic [IN_WIDTH-1:0]             inCondBr,
   input  logic [IN_WIDTH*IDX_WIDTH-1:0]   inIdx,
   input  logic [IN_WIDTH*HIST_WIDTH-1:0]  inHist,
   input  logic [IN_WIDTH*ENT_WIDTH-1:0]   inPrevEnt,
   input  logic [IN_WIDTH-1:0]             inTaken,
   output logic                            inReady,
   input  logic                            outStall,
   output logic [OUT_WIDTH-1:0]            phtWE,
   output logic [OUT_WIDTH*IDX_WIDTH-1:0]  phtWA,
   output logic [OUT_WIDTH*ENT_WIDTH-1:0]  phtWV,
   output logic                            overflow,
   output logic [$clog2(DEPTH):0]          occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   if (DEPTH < 2*IN_WIDTH || OUT_WIDTH != 2 || IDX_WIDTH > ADDR_WIDTH) begin : gBadCfg
      $error("pht_update_queue: unsupported parameter set");
   end

   logic [IDX_WIDTH-1:0]  qIdx   [DEPTH];
   logic [HIST_WIDTH-1:0] qHist  [DEPTH];
   logic [ENT_WIDTH-1:0]  qEnt   [DEPTH];
   logic                  qTaken [DEPTH];

   logic [PTR_W-1:0] head, tail, head1;
   logic [CNT_W-1:0] count, enqCnt, popCnt;
   logic [IN_WIDTH-1:0] qual, wrEn;
   logic [PTR_W-1:0] wrPtr [IN_WIDTH];
   logic pop0, pop1, mergeTwo, samePair;
   logic [ENT_WIDTH-1:0] wv0, wv1;

   function automatic logic [ENT_WIDTH-1:0] updEnt(input logic [ENT_WIDTH-1:0] ent,
                                                   input logic [HIST_WIDTH-1:0] h,
                                                   input logic tk);
      logic [CTR_WIDTH-1:0] c;
      logic [ENT_WIDTH-1:0] r;
      r = ent;
      c = ent[h*CTR_WIDTH +: CTR_WIDTH];
      if (tk) begin
         if (c != '1) c = c + CTR_WIDTH'(1);
      end else if (c != '0) begin
         c = c - CTR_WIDTH'(1);
      end
      r[h*CTR_WIDTH +: CTR_WIDTH] = c;
      return r;
   endfunction

   assign qual      = inValid & inCondBr;
   assign inReady   = count <= CNT_W'(DEPTH - IN_WIDTH);
   assign occupancy = count;

   // Qualifying lanes are packed in lane order onto consecutive tail slots.
   always_comb begin
      enqCnt = '0;
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
         wrEn[i]  = 1'b0;
         wrPtr[i] = tail + enqCnt[PTR_W-1:0];
         if (qual[i] && inReady) begin
            wrEn[i] = 1'b1;
            enqCnt  = enqCnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
         if (wrEn[i]) begin
            qIdx[wrPtr[i]]   <= inIdx[i*IDX_WIDTH +: IDX_WIDTH];
            qHist[wrPtr[i]]  <= inHist[i*HIST_WIDTH +: HIST_WIDTH];
            qEnt[wrPtr[i]]   <= inPrevEnt[i*ENT_WIDTH +: ENT_WIDTH];
            qTaken[wrPtr[i]] <= inTaken[i];
         end
      end
   end

   // Head+1 only leaves with the head when it lands in the other bank (or merges).
   always_comb begin
      head1    = head + PTR_W'(1);
      pop0     = 1'b0;
      pop1     = 1'b0;
      mergeTwo = 1'b0;
      samePair = 1'b0;
`ifdef PHT_UPD_MERGE_EN
      samePair = qIdx[head] == qIdx[head1];
`endif
      if (!outStall && count != '0) pop0 = 1'b1;
      if (!outStall && count >= CNT_W'(2)) begin
         if (samePair) mergeTwo = 1'b1;
         else if (qIdx[head][0] != qIdx[head1][0]) pop1 = 1'b1;
      end
      wv0 = updEnt(qEnt[head], qHist[head], qTaken[head]);
      if (mergeTwo) wv0 = updEnt(wv0, qHist[head1], qTaken[head1]);
      wv1 = updEnt(qEnt[head1], qHist[head1], qTaken[head1]);
      popCnt = CNT_W'(pop0) + CNT_W'(pop1 | mergeTwo);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         head  <= head + popCnt[PTR_W-1:0];
         tail  <= tail + enqCnt[PTR_W-1:0];
         count <= count + enqCnt - popCnt;
         if (!inReady && (|qual)) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         phtWE <= '0;
         phtWA <= '0;
         phtWV <= '0;
      end else begin
         phtWE <= {pop1, pop0};
         if (pop0) begin
            phtWA[0 +: IDX_WIDTH] <= qIdx[head];
            phtWV[0 +: ENT_WIDTH] <= wv0;
         end
         if (pop1) begin
            phtWA[IDX_WIDTH +: IDX_WIDTH] <= qIdx[head1];
            phtWV[ENT_WIDTH +: ENT_WIDTH] <= wv1;
         end
      end
   end

endmodule

// File: tb/tb_pht_update_queue.sv
// Scoreboard bench for pht_update_queue: expected writes are queued at drive time and
// compared in order as phtWE fires; define PHT_UPD_MERGE_EN to exercise the merged build.
module tb_pht_update_queue;

   logic        clk = 1'b0;
   logic        rstN;
   logic [1:0]  inValid, inCondBr, inTaken;
   logic [17:0] inIdx;
   logic [3:0]  inHist;
   logic [15:0] inPrevEnt;
   logic        inReady, outStall, overflow;
   logic [1:0]  phtWE;
   logic [17:0] phtWA;
   logic [15:0] phtWV;
   logic [3:0]  occupancy;

   typedef struct {
      logic [8:0] idx;
      logic [7:0] ent;
   } wr_t;

   wr_t        expQ [$];
   logic [1:0] weLog [$];
   int         total = 0;
   int         bad = 0;

   pht_update_queue #(.DEPTH(8), .IN_WIDTH(2), .OUT_WIDTH(2), .IDX_WIDTH(9),
                      .HIST_WIDTH(2), .CTR_WIDTH(2)) dut (
      .clk(clk), .rstN(rstN), .inValid(inValid), .inCondBr(inCondBr), .inIdx(inIdx),
      .inHist(inHist), .inPrevEnt(inPrevEnt), .inTaken(inTaken), .inReady(inReady),
      .outStall(outStall), .phtWE(phtWE), .phtWA(phtWA), .phtWV(phtWV),
      .overflow(overflow), .occupancy(occupancy));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(input logic [7:0] e, input int h, input bit tk);
      int c, r;
      r = int'(e);
      c = (r >> (2*h)) & 3;
      if (tk) c = (c == 3) ? 3 : c + 1;
      else    c = (c == 0) ? 0 : c - 1;
      r = (r & ~(3 << (2*h))) | (c << (2*h));
      return r[7:0];
   endfunction

   always @(negedge clk) begin
      if (rstN) begin
         if (phtWE != 2'b00) weLog.push_back(phtWE);
         for (int k = 0; k < 2; k++) begin
            if (phtWE[k]) begin
               if (expQ.size() == 0) begin
                  check("spuriousWrite", 64'(k + 1), 64'd0);
               end else begin
                  wr_t e;
                  e = expQ.pop_front();
                  check("wa", 64'(phtWA[k*9 +: 9]), 64'(e.idx));
                  check("wv", 64'(phtWV[k*8 +: 8]), 64'(e.ent));
               end
            end
         end
      end
   end

   task automatic put(input int l, input bit q, input logic [8:0] idx, input logic [1:0] h,
                      input logic [7:0] e, input bit tk, input bit acc);
      wr_t w;
      inValid[l]          = 1'b1;
      inCondBr[l]         = q;
      inIdx[l*9 +: 9]     = idx;
      inHist[l*2 +: 2]    = h;
      inPrevEnt[l*8 +: 8] = e;
      inTaken[l]          = tk;
      if (q && acc) begin
         w.idx = idx;
         w.ent = model(e, int'(h), tk);
         expQ.push_back(w);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      inValid  = '0;
      inCondBr = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (occupancy != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drainTimeout", 64'(n < 50), 64'd1);
      idle(3);
      check("drainLeft", 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      logic [8:0] ix;
      logic [7:0] ev;
      rstN = 1'b0; outStall = 1'b0;
      inValid = '0; inCondBr = '0; inTaken = '0; inIdx = '0; inHist = '0; inPrevEnt = '0;

      @(negedge clk);
      check("rstReady", 64'(inReady), 64'd1);
      check("rstWE", 64'(phtWE), 64'd0);
      check("rstWA", 64'(phtWA), 64'd0);
      check("rstWV", 64'(phtWV), 64'd0);
      check("rstOvf", 64'(overflow), 64'd0);
      check("rstOcc", 64'(occupancy), 64'd0);
      rstN = 1'b1;
      idle(1);

      // single entry latency
      weLog.delete();
      put(0, 1, 9'h004, 2'd1, 8'hAA, 1'b1, 1'b1);
      tick();
      check("latOcc1", 64'(occupancy), 64'd1);
      check("latWE0", 64'(phtWE), 64'd0);
      @(negedge clk);
      check("latWE1", 64'(phtWE), 64'd1);
      check("latOcc0", 64'(occupancy), 64'd0);
      idle(3);
      check("latLogN", 64'(weLog.size()), 64'd1);

      // different banks -> dual write, saturate at 0
      weLog.delete();
      put(0, 1, 9'h010, 2'd0, 8'h00, 1'b0, 1'b1);
      put(1, 1, 9'h011, 2'd0, 8'h00, 1'b0, 1'b1);
      tick();
      idle(4);
      check("dualN", 64'(weLog.size()), 64'd1);
      if (weLog.size() > 0) check("dualWE", 64'(weLog[0]), 64'd3);

      // same bank -> serialised
      weLog.delete();
      put(0, 1, 9'h020, 2'd2, 8'hFF, 1'b1, 1'b1);
      put(1, 1, 9'h022, 2'd0, 8'h01, 1'b0, 1'b1);
      tick();
      idle(4);
      check("bankN", 64'(weLog.size()), 64'd2);
      if (weLog.size() == 2) begin
         check("bankWE0", 64'(weLog[0]), 64'd1);
         check("bankWE1", 64'(weLog[1]), 64'd1);
      end

      // non-conditional lane 0 discarded, lane 1 compacted
      weLog.delete();
      put(0, 0, 9'h0AA, 2'd1, 8'h55, 1'b1, 1'b1);
      put(1, 1, 9'h055, 2'd3, 8'h00, 1'b1, 1'b1);
      tick();
      idle(4);
      check("compactN", 64'(weLog.size()), 64'd1);

      // fill under stall, overflow, drain
      weLog.delete();
      outStall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ix = 9'h100 + 9'(k*2); ev = 8'($urandom);
         put(0, 1, ix, 2'(k), ev, k[0], 1'b1);
         ix = 9'h101 + 9'(k*4); ev = 8'($urandom);
         put(1, 1, ix, 2'(k+1), ev, ~k[0], 1'b1);
         tick();
      end
      check("fill6Occ", 64'(occupancy), 64'd6);
      check("fill6Rdy", 64'(inReady), 64'd1);
      put(0, 1, 9'h140, 2'd3, 8'h3C, 1'b1, 1'b1);
      tick();
      check("fill7Occ", 64'(occupancy), 64'd7);
      check("fill7Rdy", 64'(inReady), 64'd0);
      check("fill7Ovf", 64'(overflow), 64'd0);
      put(0, 1, 9'h150, 2'd0, 8'h11, 1'b1, 1'b0);
      put(1, 1, 9'h151, 2'd0, 8'h11, 1'b1, 1'b0);
      tick();
      check("dropOvf", 64'(overflow), 64'd1);
      check("dropOcc", 64'(occupancy), 64'd7);
      check("stallNoWr", 64'(weLog.size()), 64'd0);
      outStall = 1'b0;
      drain();
      check("ovfSticky", 64'(overflow), 64'd1);

      outStall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ix = 9'h180 + 9'(k); ev = 8'($urandom);
         put(0, 1, ix, 2'(k), ev, 1'b1, 1'b1);
         ix = 9'h190 + 9'(k*3); ev = 8'($urandom);
         put(1, 1, ix, 2'(3-k), ev, 1'b0, 1'b1);
         tick();
      end
      check("fullOcc", 64'(occupancy), 64'd8);
      check("fullRdy", 64'(inReady), 64'd0);
      outStall = 1'b0;
      drain();

      // equal index pair
      weLog.delete();
      put(0, 1, 9'h030, 2'd3, 8'h40, 1'b1, 1'b0);
      put(1, 1, 9'h030, 2'd3, 8'h40, 1'b1, 1'b0);
`ifdef PHT_UPD_MERGE_EN
      expQ.push_back('{9'h030, 8'hC0});
      tick();
      idle(4);
      check("mergeN", 64'(weLog.size()), 64'd1);
      if (weLog.size() > 0) check("mergeWE", 64'(weLog[0]), 64'd1);
`else
      expQ.push_back('{9'h030, 8'h80});
      expQ.push_back('{9'h030, 8'h80});
      tick();
      idle(4);
      check("sameIdxN", 64'(weLog.size()), 64'd2);
`endif

      // asynchronous reset mid-drain
      outStall = 1'b1;
      put(0, 1, 9'h200, 2'd0, 8'h00, 1'b1, 1'b1);
      put(1, 1, 9'h201, 2'd0, 8'h00, 1'b1, 1'b1);
      tick();
      put(0, 1, 9'h202, 2'd1, 8'h00, 1'b1, 1'b1);
      put(1, 1, 9'h203, 2'd1, 8'h00, 1'b1, 1'b1);
      tick();
      put(0, 1, 9'h204, 2'd2, 8'h00, 1'b1, 1'b1);
      tick();
      check("preRstOcc", 64'(occupancy), 64'd5);
      outStall = 1'b0;
      @(negedge clk);
      check("preRstWE", 64'(phtWE != 2'b00), 64'd1);
      #2 rstN = 1'b0;
      #1;
      check("asyncOcc", 64'(occupancy), 64'd0);
      check("asyncWE", 64'(phtWE), 64'd0);
      check("asyncOvf", 64'(overflow), 64'd0);
      expQ.delete();
      weLog.delete();
      idle(2);
      rstN = 1'b1;
      idle(6);
      check("postRstNoWr", 64'(weLog.size()), 64'd0);
      check("postRstOcc", 64'(occupancy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
